// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: PC generation, SRAM request issue with bounded in-flight
// fetches, in-order response matching, and an instruction queue feeding the ID stage.
module if_fetch_queue #(
   parameter logic [31:0] RESET_PC        = 32'h1c000000,
   parameter int          MAX_OUTSTANDING = 2,
   parameter int          IBUF_DEPTH      = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        id_allowin,
   output logic        if_id_valid,
   output logic [69:0] if_id_bus,
   input  logic        br_taken,
   input  logic        br_stall,
   input  logic [31:0] br_target,
   input  logic        wb_exc,
   input  logic [31:0] exc_entaddr,
   input  logic        ertn_flush,
   input  logic [31:0] exc_retaddr,
   output logic        inst_sram_req,
   output logic        inst_sram_wr,
   output logic [1:0]  inst_sram_size,
   output logic [3:0]  inst_sram_wstrb,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata,
   input  logic        inst_sram_addr_ok,
   input  logic        inst_sram_data_ok,
   input  logic [31:0] inst_sram_rdata
);

   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int QW = $clog2(IBUF_DEPTH);
   localparam int CW = $clog2(IBUF_DEPTH + 1);
   localparam int SW = ((CW > OW) ? CW : OW) + 1;
   localparam logic [5:0] EXC_ADEF = 6'b000001;

   logic [31:0] fetch_pc;
   logic        halted;
   logic        started;
   logic [OW-1:0] outstanding;
   logic [OW-1:0] outstanding_next;
   logic [OW-1:0] cancel;
   logic [31:0] pc_fifo [MAX_OUTSTANDING];
   logic [PW-1:0] pf_wr;
   logic [PW-1:0] pf_rd;
   logic [69:0] queue [IBUF_DEPTH];
   logic [QW-1:0] q_wr;
   logic [QW-1:0] q_rd;
   logic [CW-1:0] q_count;

   logic        redirect_now;
   logic [31:0] redirect_target;
   logic        aligned;
   logic        space_ok;
   logic        req_fire;
   logic        resp_pop;
   logic        resp_keep;
   logic        adef_push;
   logic        q_push;
   logic        q_pop;
   logic [69:0] push_entry;

   assign inst_sram_wr    = 1'b0;
   assign inst_sram_size  = 2'h2;
   assign inst_sram_wstrb = 4'h0;
   assign inst_sram_wdata = 32'h0;
   assign inst_sram_addr  = fetch_pc;

   // Redirect selection, issue gating and queue push/pop decisions
   always_comb begin
      redirect_now = wb_exc | ertn_flush | (br_taken & ~br_stall);
      if (wb_exc) begin
         redirect_target = exc_entaddr;
      end else if (ertn_flush) begin
         redirect_target = exc_retaddr;
      end else begin
         redirect_target = br_target;
      end
      aligned  = (fetch_pc[1:0] == 2'b00);
      // Reserve queue space for every in-flight fetch so responses can always be stored
      space_ok = (SW'(q_count) + SW'(outstanding)) < SW'(IBUF_DEPTH);
      inst_sram_req = started & ~halted & ~br_stall & ~redirect_now &
                      (outstanding < OW'(MAX_OUTSTANDING)) & space_ok & aligned;
      req_fire  = inst_sram_req & inst_sram_addr_ok;
      resp_pop  = inst_sram_data_ok & (outstanding != {OW{1'b0}});
      resp_keep = resp_pop & (cancel == {OW{1'b0}});
      adef_push = started & ~halted & ~redirect_now & ~aligned &
                  (outstanding == {OW{1'b0}}) & (cancel == {OW{1'b0}}) & space_ok;
      q_push = ~redirect_now & (resp_keep | adef_push);
      if (adef_push) begin
         push_entry = {EXC_ADEF, fetch_pc, 32'h0};
      end else begin
         push_entry = {6'h0, pc_fifo[pf_rd], inst_sram_rdata};
      end
      if_id_valid = (q_count != {CW{1'b0}}) & ~redirect_now;
      q_pop       = if_id_valid & id_allowin;
      if_id_bus   = queue[q_rd];
   end

   // In-flight count after this cycle's accept and response
   always_comb begin
      if (req_fire && !resp_pop) begin
         outstanding_next = outstanding + OW'(1);
      end else if (!req_fire && resp_pop) begin
         outstanding_next = outstanding - OW'(1);
      end else begin
         outstanding_next = outstanding;
      end
   end

   // Fetch PC, halt flag and start-up delay
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         halted   <= 1'b0;
         started  <= 1'b0;
      end else begin
         started <= 1'b1;
         if (redirect_now) begin
            fetch_pc <= redirect_target;
            halted   <= 1'b0;
         end else begin
            if (req_fire) begin
               fetch_pc <= fetch_pc + 32'd4;
            end
            if (adef_push) begin
               halted <= 1'b1;
            end
         end
      end
   end

   // Outstanding and cancel counters; a redirect marks every still-pending fetch stale
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         outstanding <= {OW{1'b0}};
         cancel      <= {OW{1'b0}};
      end else begin
         outstanding <= outstanding_next;
         if (redirect_now) begin
            cancel <= outstanding_next;
         end else if (resp_pop && (cancel != {OW{1'b0}})) begin
            cancel <= cancel - OW'(1);
         end
      end
   end

   // PC FIFO pointers, advanced on accept and on every response (kept or dropped)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pf_wr <= {PW{1'b0}};
         pf_rd <= {PW{1'b0}};
      end else begin
         if (req_fire) begin
            pf_wr <= (pf_wr == PW'(MAX_OUTSTANDING - 1)) ? {PW{1'b0}} : pf_wr + PW'(1);
         end
         if (resp_pop) begin
            pf_rd <= (pf_rd == PW'(MAX_OUTSTANDING - 1)) ? {PW{1'b0}} : pf_rd + PW'(1);
         end
      end
   end

   // PC FIFO storage
   always_ff @(posedge clk) begin
      if (req_fire) begin
         pc_fifo[pf_wr] <= fetch_pc;
      end
   end

   // Instruction queue pointers and occupancy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_wr    <= {QW{1'b0}};
         q_rd    <= {QW{1'b0}};
         q_count <= {CW{1'b0}};
      end else if (redirect_now) begin
         q_wr    <= {QW{1'b0}};
         q_rd    <= {QW{1'b0}};
         q_count <= {CW{1'b0}};
      end else begin
         if (q_push) begin
            q_wr <= q_wr + QW'(1);
         end
         if (q_pop) begin
            q_rd <= q_rd + QW'(1);
         end
         q_count <= q_count + CW'(q_push) - CW'(q_pop);
      end
   end

   // Instruction queue storage
   always_ff @(posedge clk) begin
      if (q_push) begin
         queue[q_wr] <= push_entry;
      end
   end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomised scoreboard bench for if_fetch_queue: an SRAM model with variable latency,
// and an expected-stream queue refilled on every redirect/reset.
module tb_if_fetch_queue;

   localparam logic [31:0] RPC = 32'h1c000000;
   localparam int MO    = 2;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_allowin;
   logic        if_id_valid;
   logic [69:0] if_id_bus;
   logic        br_taken, br_stall, wb_exc, ertn_flush;
   logic [31:0] br_target, exc_entaddr, exc_retaddr;
   logic        inst_sram_req, inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [3:0]  inst_sram_wstrb;
   logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
   logic        inst_sram_addr_ok, inst_sram_data_ok;

   if_fetch_queue #(.RESET_PC(RPC), .MAX_OUTSTANDING(MO), .IBUF_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .id_allowin(id_allowin),
      .if_id_valid(if_id_valid), .if_id_bus(if_id_bus),
      .br_taken(br_taken), .br_stall(br_stall), .br_target(br_target),
      .wb_exc(wb_exc), .exc_entaddr(exc_entaddr),
      .ertn_flush(ertn_flush), .exc_retaddr(exc_retaddr),
      .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
      .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
      .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
      .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
      .inst_sram_rdata(inst_sram_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          rdy;
   } pend_t;

   int          vectors = 0;
   int          miscompares = 0;
   int          deliveries = 0;
   int          cyc = 0;
   int          aok_pct = 100;
   int          dly_min = 0;
   int          dly_max = 0;
   logic        forbid_en = 1'b0;
   logic [31:0] forbid_addr = 32'h0;
   logic [69:0] exp_q[$];
   pend_t       pend[$];

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return a ^ 32'h3c5a96e1;
   endfunction

   task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected response to a redirect/reset: the sequential stream from the target,
   // or a single ADEF entry when the target is misaligned.
   task automatic expect_stream(input logic [31:0] t);
      logic [31:0] pc;
      exp_q.delete();
      if (t[1:0] != 2'b00) begin
         exp_q.push_back({6'b000001, t, 32'h0});
      end else begin
         for (int i = 0; i < 512; i++) begin
            pc = t + 32'(4 * i);
            exp_q.push_back({6'b000000, pc, mem_f(pc)});
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic redirect(input logic e, input logic r, input logic b, input logic [31:0] t);
      wb_exc = e; ertn_flush = r; br_taken = b;
      if (e) exc_entaddr = t;
      else if (r) exc_retaddr = t;
      else br_target = t;
      expect_stream(t);
      tick();
      wb_exc = 1'b0; ertn_flush = 1'b0; br_taken = 1'b0;
   endtask

   task automatic wait_deliv(input string name, input int n, input int budget);
      int start;
      start = deliveries;
      for (int i = 0; i < budget; i++) begin
         if (deliveries - start >= n) break;
         tick();
      end
      check(name, 70'(deliveries - start >= n), 70'(1));
   endtask

   function automatic logic [31:0] rnd_target();
      logic [31:0] t;
      t = 32'h1c000000 + ($urandom_range(1023) << 2);
      if ($urandom_range(9) == 0) t[1:0] = 2'($urandom_range(3, 1));
      return t;
   endfunction

   // SRAM model: in-order responses with a programmable latency window
   initial begin : sram
      pend_t e;
      inst_sram_addr_ok = 1'b0;
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (reset) begin
            pend.delete();
            inst_sram_addr_ok = 1'b0;
            inst_sram_data_ok = 1'b0;
         end else begin
            inst_sram_addr_ok = ($urandom_range(99) < aok_pct);
            if (pend.size() > 0 && pend[0].rdy <= cyc) begin
               inst_sram_data_ok = 1'b1;
               inst_sram_rdata   = mem_f(pend[0].addr);
            end else begin
               inst_sram_data_ok = 1'b0;
               inst_sram_rdata   = $urandom;
            end
         end
         @(negedge clk);
         if (!reset) begin
            if (inst_sram_data_ok) void'(pend.pop_front());
            if (inst_sram_req && inst_sram_addr_ok) begin
               e.addr = inst_sram_addr;
               e.rdy  = cyc + 1 + int'($urandom_range(dly_max, dly_min));
               pend.push_back(e);
               check("outstanding_bound", 70'(pend.size() <= MO), 70'(1));
               if (forbid_en) check("forbidden_fetch", 70'(inst_sram_addr != forbid_addr), 70'(1));
            end
         end
      end
   end

   // Monitor: pops the expected stream on every ID handshake
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (inst_sram_req) begin
               check("req_aligned", 70'(inst_sram_addr[1:0]), 70'(0));
               check("req_consts", {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata},
                     70'({1'b0, 2'h2, 4'h0, 32'h0}));
            end
            if (if_id_valid && id_allowin) begin
               deliveries++;
               if (exp_q.size() == 0) begin
                  check("unexpected_delivery", if_id_bus, 70'(0));
               end else begin
                  check("deliver", if_id_bus, exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int start;
      reset = 1'b1; id_allowin = 1'b1;
      br_taken = 1'b0; br_stall = 1'b0; wb_exc = 1'b0; ertn_flush = 1'b0;
      br_target = 32'h0; exc_entaddr = 32'h0; exc_retaddr = 32'h0;
      expect_stream(RPC);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_valid_req", 70'({if_id_valid, inst_sram_req}), 70'(0));
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("first_cycle_valid_req", 70'({if_id_valid, inst_sram_req}), 70'(0));
      tick();

      // Back-to-back delivery from reset PC
      wait_deliv("first_delivery", 1, 20);
      start = deliveries;
      repeat (8) tick();
      check("throughput", 70'(deliveries - start), 70'(8));

      // ID stall fills the queue; drain shows exactly DEPTH buffered entries
      id_allowin = 1'b0;
      repeat (10) tick();
      check("stall_req_low", 70'(inst_sram_req), 70'(0));
      check("stall_valid", 70'(if_id_valid), 70'(1));
      check("stall_no_inflight", 70'(pend.size()), 70'(0));
      aok_pct = 0; id_allowin = 1'b1;
      start = deliveries;
      repeat (DEPTH + 3) tick();
      check("drain_count", 70'(deliveries - start), 70'(DEPTH));
      aok_pct = 100;

      // Branch with two fetches in flight
      dly_min = 3; dly_max = 3;
      for (int i = 0; i < 20; i++) begin
         if (pend.size() == MO) break;
         tick();
      end
      check("two_inflight", 70'(pend.size()), 70'(MO));
      redirect(1'b0, 1'b0, 1'b1, 32'h1c000100);
      dly_min = 0; dly_max = 0;
      wait_deliv("after_branch", 2, 40);

      // br_taken while stalled must be ignored
      br_stall = 1'b1; br_taken = 1'b1; br_target = 32'h1c000800;
      tick();
      br_stall = 1'b0; br_taken = 1'b0;
      wait_deliv("stalled_branch_ignored", 3, 40);

      // Exception beats branch in the same cycle
      forbid_en = 1'b1; forbid_addr = 32'h1c000200;
      wb_exc = 1'b1; exc_entaddr = 32'h1c008000; br_taken = 1'b1; br_target = 32'h1c000200;
      expect_stream(32'h1c008000);
      tick();
      wb_exc = 1'b0; br_taken = 1'b0;
      wait_deliv("exc_priority", 4, 40);
      forbid_en = 1'b0;

      // Misaligned branch target: one ADEF entry, then idle until ertn
      redirect(1'b0, 1'b0, 1'b1, 32'h1c000102);
      wait_deliv("adef_entry", 1, 40);
      start = deliveries;
      repeat (15) tick();
      check("halted_req_low", 70'(inst_sram_req), 70'(0));
      check("halted_no_delivery", 70'(deliveries - start), 70'(0));
      redirect(1'b0, 1'b1, 1'b0, 32'h1c000400);
      wait_deliv("after_ertn", 3, 40);

      // PC wrap past the top of the address space
      redirect(1'b1, 1'b0, 1'b0, 32'hfffffff8);
      wait_deliv("pc_wrap", 4, 40);

      // Randomised traffic with redirects, stalls and one mid-run reset
      aok_pct = 60; dly_min = 0; dly_max = 4;
      start = deliveries;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            wb_exc = 1'b0; ertn_flush = 1'b0; br_taken = 1'b0; br_stall = 1'b0;
            reset = 1'b1;
            expect_stream(RPC);
            tick(); tick();
            reset = 1'b0;
            tick();
         end else begin
            id_allowin  = ($urandom_range(99) < 75);
            br_stall    = ($urandom_range(99) < 10);
            wb_exc      = ($urandom_range(99) < 1);
            ertn_flush  = ($urandom_range(99) < 1);
            br_taken    = ($urandom_range(99) < 3);
            exc_entaddr = rnd_target();
            exc_retaddr = rnd_target();
            br_target   = rnd_target();
            if (wb_exc) expect_stream(exc_entaddr);
            else if (ertn_flush) expect_stream(exc_retaddr);
            else if (br_taken && !br_stall) expect_stream(br_target);
            tick();
         end
      end
      wb_exc = 1'b0; ertn_flush = 1'b0; br_taken = 1'b0; br_stall = 1'b0;
      id_allowin = 1'b1;
      repeat (20) tick();
      check("random_progress", 70'(deliveries - start >= 200), 70'(1));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
